// File: rtl/tape_pulse_player.sv
// Tape pulse player: turns a stream of 16-bit little-endian pulse lengths
// read from the hyperload FIFO into a regenerated tape EAR waveform.
// Each nonzero word toggles ear_out and then holds it for that many
// tick_en strobes; a zero word is a pause marker that parks ear_out at
// IDLE_LEVEL. Dropping play returns to IDLE on the next edge.
module tape_pulse_player #(
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic        clk48,
  input  logic        reset_n,
  input  logic        tick_en,
  input  logic        play,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd,
  output logic        ear_out,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] pulse_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH_LO = 3'd1,
    S_CAP_LO   = 3'd2,
    S_FETCH_HI = 3'd3,
    S_CAP_HI   = 3'd4,
    S_COUNT    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  lo_q, lo_d;
  logic        ear_q, ear_d;
  logic        underrun_q, underrun_d;
  logic [15:0] pcount_q, pcount_d;
  // Set once a word has been taken since play rose; distinguishes a normal
  // first fetch from the stream running dry between words.
  logic        consumed_q, consumed_d;

  // The word is assembled combinationally in CAP_HI: high byte straight
  // from the FIFO read data, low byte from the latch filled in CAP_LO.
  logic [15:0] word;
  assign word = {fifo_data, lo_q};

  // State and datapath registers, all cleared asynchronously.
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 16'd0;
      lo_q       <= 8'd0;
      ear_q      <= IDLE_LEVEL;
      underrun_q <= 1'b0;
      pcount_q   <= 16'd0;
      consumed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      ear_q      <= ear_d;
      underrun_q <= underrun_d;
      pcount_q   <= pcount_d;
      consumed_q <= consumed_d;
    end
  end

  // Next-state logic and the FIFO read strobe. fifo_rd is a decode of the
  // current state gated by play and fifo_empty, so it can never fire on an
  // empty FIFO or while stopped, and lasts one cycle because FETCH_x always
  // advances to CAP_x when it reads.
  always_comb begin
    state_d = state_q;
    fifo_rd = 1'b0;
    if (!play) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) state_d = S_FETCH_LO;
        end
        S_FETCH_LO: begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            state_d = S_CAP_LO;
          end
        end
        S_CAP_LO: begin
          state_d = S_FETCH_HI;
        end
        S_FETCH_HI: begin
          if (!fifo_empty) begin
            fifo_rd = 1'b1;
            state_d = S_CAP_HI;
          end
        end
        S_CAP_HI: begin
          if (word != 16'd0) state_d = S_COUNT;
          else               state_d = S_FETCH_LO;
        end
        S_COUNT: begin
          if (tick_en && (cnt_q == 16'd1)) state_d = S_FETCH_LO;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Datapath updates: byte latch, down-counter, EAR level, pulse counter
  // and the sticky underrun flag. Stopping clears everything except
  // pulse_count, which only reset clears.
  always_comb begin
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    ear_d      = ear_q;
    underrun_d = underrun_q;
    pcount_d   = pcount_q;
    consumed_d = consumed_q;
    if (!play) begin
      cnt_d      = 16'd0;
      lo_d       = 8'd0;
      ear_d      = IDLE_LEVEL;
      underrun_d = 1'b0;
      consumed_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ear_d = IDLE_LEVEL;
        end
        S_FETCH_LO: begin
          // An empty FIFO before the first word is just a slow start;
          // after a word it means the stream broke mid-flight.
          if (fifo_empty && consumed_q) underrun_d = 1'b1;
        end
        S_CAP_LO: begin
          lo_d = fifo_data;
        end
        S_FETCH_HI: begin
          // Half a word is already in hand, so waiting here is always
          // an underrun.
          if (fifo_empty) underrun_d = 1'b1;
        end
        S_CAP_HI: begin
          consumed_d = 1'b1;
          if (word != 16'd0) begin
            ear_d    = ~ear_q;
            cnt_d    = word;
            pcount_d = pcount_q + 16'd1;
          end else begin
            ear_d = IDLE_LEVEL;
          end
        end
        S_COUNT: begin
          if (tick_en) cnt_d = cnt_q - 16'd1;
        end
        default: begin
          cnt_d = 16'd0;
        end
      endcase
    end
  end

  assign ear_out     = ear_q;
  assign busy        = (state_q != S_IDLE);
  assign underrun    = underrun_q;
  assign pulse_count = pcount_q;

endmodule

// File: tb/tb_tape_pulse_player.sv
// Bench for tape_pulse_player: a FIFO model feeds byte streams, a
// reference model turns each stream into the list of observable EAR/count
// changes (with expected tick count and edge delay), and a monitor pops
// that list whenever the DUT's ear_out or pulse_count changes.
module tb_tape_pulse_player;

  localparam logic IDLE_LEVEL = 1'b0;

  logic        clk48 = 1'b0;
  logic        reset_n;
  logic        tick_en;
  logic        play;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd;
  logic        ear_out;
  logic        busy;
  logic        underrun;
  logic [15:0] pulse_count;

  tape_pulse_player #(.IDLE_LEVEL(IDLE_LEVEL)) dut (
    .clk48       (clk48),
    .reset_n     (reset_n),
    .tick_en     (tick_en),
    .play        (play),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .ear_out     (ear_out),
    .busy        (busy),
    .underrun    (underrun),
    .pulse_count (pulse_count)
  );

  always #5 clk48 = ~clk48;

  typedef struct {
    logic lvl;
    int   cnt;
    int   ticks;
    int   dly;
    bit   chk;
  } ev_t;

  int  n_vec = 0;
  int  n_err = 0;
  int  cyc = 0;
  ev_t sb[$];
  ev_t me;
  byte unsigned fq[$];
  byte unsigned bq[$];
  int  tick_mode = 0;
  int  gap = 0;
  bit  mon_en = 0;
  logic m_lvl;
  int  m_cnt;
  int  ticks_since = 0;
  int  last_tick = -100;
  logic prev_ear = 1'b0;
  logic [15:0] prev_cnt = 16'd0;
  logic prev_ur = 1'b0;
  int  ur_cyc = 0, ur_ticks = 0, ur_last_tick = 0;
  int  ev_cyc[$];
  int  rd_total = 0;
  logic rd_at_edge = 1'b0, empty_at_edge = 1'b1, play_at_edge = 1'b0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_ev(input logic l, input int c, input int t, input int d, input bit ck);
    ev_t e;
    e.lvl = l; e.cnt = c; e.ticks = t; e.dly = d; e.chk = ck;
    sb.push_back(e);
  endfunction

  function automatic void add_word(input logic [15:0] w);
    bq.push_back(w[7:0]);
    bq.push_back(w[15:8]);
  endfunction

  // Reference model. A captured nonzero word toggles the level and bumps
  // the count; a zero word parks the level at IDLE_LEVEL (visible only if it
  // was not already there). With the FIFO kept full, a word is captured 4
  // edges after the previous pulse's expiring tick, and a marker is
  // followed by the next capture 4 edges later.
  task automatic expect_stream(input bit timing);
    int p = 0, d = 0, prev_len = 0;
    bit have_ref = 0, prev_nz = 0, first = 1;
    logic [15:0] w;
    for (int i = 0; i + 1 < bq.size(); i += 2) begin
      w = {bq[i+1], bq[i]};
      if (!first) begin
        if (prev_nz) begin p += prev_len; d = 4; end
        else d += 4;
      end
      if (w != 16'd0) begin
        m_lvl = ~m_lvl;
        m_cnt = (m_cnt + 1) & 16'hFFFF;
        push_ev(m_lvl, m_cnt, p, d, timing && have_ref);
        have_ref = 1; p = 0;
      end else if (m_lvl != IDLE_LEVEL) begin
        m_lvl = IDLE_LEVEL;
        push_ev(m_lvl, m_cnt, p, d, timing && have_ref);
        have_ref = 1; p = 0;
      end
      prev_nz = (w != 16'd0);
      prev_len = int'(w);
      first = 0;
    end
  endtask

  // tick_en generator: off, held high, or single strobes at least 9 edges
  // apart so no strobe lands in the fetch/capture window after an expiry.
  initial begin
    tick_en = 1'b0;
    forever begin
      @(negedge clk48);
      case (tick_mode)
        0: tick_en = 1'b0;
        1: tick_en = 1'b1;
        default: begin
          if (gap == 0) begin
            tick_en = 1'b1;
            gap = $urandom_range(13, 8);
          end else begin
            tick_en = 1'b0;
            gap--;
          end
        end
      endcase
    end
  end

  always @(posedge clk48) begin
    rd_at_edge    <= fifo_rd;
    empty_at_edge <= fifo_empty;
    play_at_edge  <= play;
  end

  // FIFO model: a read accepted at an edge presents its byte during the
  // following cycle.
  initial begin
    fifo_data  = 8'h00;
    fifo_empty = 1'b1;
    forever begin
      @(negedge clk48);
      if (rd_at_edge) begin
        rd_total++;
        chk("rd_when_empty", empty_at_edge, 0);
        chk("rd_without_play", play_at_edge, 1);
        if (fq.size() > 0) fifo_data = fq.pop_front();
      end
      fifo_empty = (fq.size() == 0);
    end
  end

  // Monitor: every change of ear_out or pulse_count must match the next
  // scoreboard entry.
  initial begin
    forever begin
      @(posedge clk48);
      #1;
      cyc++;
      if (tick_en) begin
        ticks_since++;
        last_tick = cyc;
      end
      if (underrun && !prev_ur) begin
        ur_cyc = cyc; ur_ticks = ticks_since; ur_last_tick = last_tick;
      end
      if (mon_en && (ear_out !== prev_ear || pulse_count !== prev_cnt)) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_event: ear=%0b count=%0d, expected no change (t=%0t)",
                   ear_out, pulse_count, $time);
        end else begin
          me = sb.pop_front();
          chk("ev_level", ear_out, me.lvl);
          chk("ev_count", pulse_count, me.cnt);
          if (me.chk) begin
            chk("ev_ticks", ticks_since, me.ticks);
            chk("ev_delay", cyc - last_tick, me.dly);
          end
        end
        ev_cyc.push_back(cyc);
        ticks_since = 0;
      end
      prev_ear = ear_out;
      prev_cnt = pulse_count;
      prev_ur  = underrun;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk48);
  endtask

  task automatic do_reset();
    mon_en = 0;
    @(negedge clk48);
    reset_n = 1'b0;
    play = 1'b0;
    fq.delete();
    sb.delete();
    m_lvl = IDLE_LEVEL;
    m_cnt = 0;
    cycles(3);
    reset_n = 1'b1;
    cycles(1);
    mon_en = 1;
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (sb.size() != 0 && k < 4000) begin
      @(negedge clk48);
      k++;
    end
    chk({nm, "_pending_events"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_ur(input string nm);
    int k = 0;
    while (underrun !== 1'b1 && k < 3000) begin
      @(negedge clk48);
      k++;
    end
    chk({nm, "_underrun"}, underrun, 1);
  endtask

  task automatic start_stream(input bit timing);
    expect_stream(timing);
    foreach (bq[i]) fq.push_back(bq[i]);
    @(negedge clk48);
    play = 1'b1;
  endtask

  task automatic stop_play(input string nm);
    @(negedge clk48);
    play = 1'b0;
    if (m_lvl != IDLE_LEVEL) begin
      m_lvl = IDLE_LEVEL;
      push_ev(IDLE_LEVEL, m_cnt, 0, 0, 0);
    end
    @(posedge clk48);
    #1;
    chk({nm, "_stop_busy"}, busy, 0);
    chk({nm, "_stop_ear"}, ear_out, IDLE_LEVEL);
    chk({nm, "_stop_underrun"}, underrun, 0);
    wait_drain({nm, "_stop"});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, nw, lastw;
    bit last_m;
    logic [15:0] w;

    reset_n = 1'b1;
    play = 1'b0;
    m_lvl = IDLE_LEVEL;
    m_cnt = 0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ear", ear_out, IDLE_LEVEL);
    chk("rst_busy", busy, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_count", pulse_count, 0);
    chk("rst_fifo_rd", fifo_rd, 0);
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
    chk("rst_idle_busy", busy, 0);
    mon_en = 1;

    // Single word then dry FIFO.
    tick_mode = 2;
    r0 = rd_total;
    bq.delete(); add_word(16'h0003);
    start_stream(1);
    wait_drain("w3");
    wait_ur("w3");
    chk("w3_hold_ticks", ur_ticks, 3);
    chk("w3_ur_delay", ur_cyc - ur_last_tick, 1);
    chk("w3_ear", ear_out, 1);
    chk("w3_count", pulse_count, 1);
    chk("w3_reads", rd_total - r0, 2);
    stop_play("w3");

    // Word, marker, word.
    do_reset();
    bq.delete(); add_word(16'h0002); add_word(16'h0000); add_word(16'h0001);
    start_stream(1);
    wait_drain("mark");
    wait_ur("mark");
    chk("mark_count", pulse_count, 2);
    chk("mark_ear", ear_out, 1);
    stop_play("mark");
    chk("count_kept_on_stop", pulse_count, 2);

    // Stall with half a word in hand, then resume.
    r0 = rd_total;
    bq.delete(); add_word(16'h0005); add_word(16'h0001);
    expect_stream(1);
    fq.push_back(8'h05);
    @(negedge clk48);
    play = 1'b1;
    cycles(20);
    chk("stall_underrun", underrun, 1);
    chk("stall_reads", rd_total - r0, 1);
    chk("stall_busy", busy, 1);
    chk("stall_no_event", sb.size(), 2);
    fq.push_back(8'h00); fq.push_back(8'h01); fq.push_back(8'h00);
    wait_drain("stall");
    chk("stall_underrun_sticky", underrun, 1);
    stop_play("stall");

    // Stop during COUNT with a non-empty FIFO.
    bq.delete(); add_word(16'h0040);
    expect_stream(0);
    fq.push_back(8'h40);
    @(negedge clk48);
    play = 1'b1;
    cycles(10);
    chk("cstop_underrun_before", underrun, 1);
    fq.push_back(8'h00);
    wait_drain("cstop_run");
    cycles(5);
    for (int i = 0; i < 4; i++) fq.push_back(8'h11);
    r0 = rd_total;
    stop_play("cstop");
    cycles(20);
    chk("cstop_no_reads", rd_total - r0, 0);
    fq.delete();
    cycles(2);

    // tick_en held high: length-1 pulses give a 5-cycle period.
    do_reset();
    tick_mode = 1;
    ev_cyc.delete();
    bq.delete();
    for (int i = 0; i < 4; i++) add_word(16'h0001);
    start_stream(0);
    wait_drain("period");
    wait_ur("period");
    chk("period_events", ev_cyc.size(), 4);
    for (int i = 1; i < ev_cyc.size(); i++) chk("period_cycles", ev_cyc[i] - ev_cyc[i-1], 5);
    chk("period_count", pulse_count, 4);
    stop_play("period");

    // High byte of the length: 0x0100 with ticks held high lasts 256+4 cycles.
    ev_cyc.delete();
    bq.delete(); add_word(16'h0100); add_word(16'h0001);
    start_stream(0);
    wait_drain("hibyte");
    chk("hibyte_events", ev_cyc.size(), 2);
    if (ev_cyc.size() == 2) chk("hibyte_cycles", ev_cyc[1] - ev_cyc[0], 260);
    stop_play("hibyte");

    // Random streams with spaced ticks.
    tick_mode = 2;
    for (int s = 0; s < 6; s++) begin
      bq.delete();
      nw = $urandom_range(10, 4);
      last_m = 1;
      lastw = 0;
      for (int i = 0; i < nw; i++) begin
        if (!last_m && $urandom_range(3, 0) == 0) begin
          w = 16'd0; last_m = 1;
        end else begin
          w = 16'($urandom_range(6, 1)); last_m = 0;
        end
        add_word(w);
        lastw = int'(w);
      end
      start_stream(1);
      wait_drain("rand");
      wait_ur("rand");
      if (lastw != 0) begin
        chk("rand_last_ticks", ur_ticks, lastw);
        chk("rand_ur_delay", ur_cyc - ur_last_tick, 1);
      end
      chk("rand_count", pulse_count, m_cnt);
      stop_play("rand");
    end

    // Asynchronous reset in the middle of COUNT with underrun set.
    bq.delete(); add_word(16'h0030);
    expect_stream(0);
    fq.push_back(8'h30);
    @(negedge clk48);
    play = 1'b1;
    cycles(8);
    fq.push_back(8'h00);
    wait_drain("arst_run");
    cycles(3);
    chk("arst_pre_underrun", underrun, 1);
    chk("arst_pre_busy", busy, 1);
    mon_en = 0;
    #2;
    reset_n = 1'b0;
    play = 1'b0;
    #1;
    chk("arst_ear", ear_out, IDLE_LEVEL);
    chk("arst_busy", busy, 0);
    chk("arst_underrun", underrun, 0);
    chk("arst_count", pulse_count, 0);
    chk("arst_fifo_rd", fifo_rd, 0);
    for (int i = 0; i < 4; i++) fq.push_back(8'h22);
    @(negedge clk48);
    reset_n = 1'b1;
    r0 = rd_total;
    cycles(20);
    chk("arst_no_reads", rd_total - r0, 0);
    chk("arst_idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tape_pulse_player.md
TAPE_PULSE_PLAYER -- requirements
Module: tape_pulse_player

Interface
REQ-001 SHALL have parameter IDLE_LEVEL, default 1'b0: ear_out level when idle, stopped, or at a pause marker.
REQ-002 SHALL have port clk48  input  1: single clock, all logic rising-edge.
REQ-003 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port tick_en  input  1: one-cycle time-base strobe (clk390k625 rate), the pulse-length unit.
REQ-005 SHALL have port play  input  1: level enable; 0 stops playback.
REQ-006 SHALL have port fifo_empty  input  1: hyperload FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  8: FIFO read data, valid the cycle after fifo_rd.
REQ-008 SHALL have port fifo_rd  output  1: one-cycle FIFO read strobe.
REQ-009 SHALL have port ear_out  output  1: regenerated tape EAR signal.
REQ-010 SHALL have port busy  output  1: high whenever state is not IDLE.
REQ-011 SHALL have port underrun  output  1: sticky; FIFO ran dry mid-stream.
REQ-012 SHALL have port pulse_count  output  16: number of ear_out toggles since reset.

Function
REQ-013 Stream format SHALL be 16-bit little-endian words (low byte first); each word is a pulse length in tick_en units; 0x0000 is a pause marker.
REQ-014 States SHALL be IDLE, FETCH_LO, CAP_LO, FETCH_HI, CAP_HI, COUNT.
REQ-015 IDLE: ear_out = IDLE_LEVEL; go to FETCH_LO when play=1 and fifo_empty=0.
REQ-016 FETCH_LO/FETCH_HI: assert fifo_rd for exactly one cycle when fifo_empty=0, then go to CAP_LO/CAP_HI; while fifo_empty=1, fifo_rd=0 and state holds.
REQ-017 CAP_LO: latch fifo_data as low byte, then go to FETCH_HI.
REQ-018 CAP_HI, word nonzero: toggle ear_out, load the down-counter with the word, increment pulse_count (wrap 0xFFFF->0x0000), then go to COUNT.
REQ-019 CAP_HI, word 0x0000: force ear_out to IDLE_LEVEL, leave pulse_count unchanged, then go to FETCH_LO.
REQ-020 COUNT: decrement the counter on each tick_en; on a tick_en with counter==1, go to FETCH_LO.
REQ-021 tick_en SHALL be ignored outside COUNT.
REQ-022 Edge timing: ear_out SHALL change on the 4th clk48 edge after the expiring-tick edge when the FIFO is non-empty; a length-1 pulse with tick_en held high SHALL give a 5-cycle toggle period.
REQ-023 underrun SHALL set when in FETCH_HI with fifo_empty=1, or in FETCH_LO with fifo_empty=1 after at least one word has been consumed since play rose. ear_out holds its level during underrun, and playback resumes when data arrives.
REQ-024 underrun SHALL clear only on reset or when play=0.
REQ-025 play=0 in any state SHALL force IDLE on the next edge: ear_out=IDLE_LEVEL, counter cleared, partial low byte discarded, fifo_rd=0 that cycle and after.
REQ-026 fifo_rd SHALL never be asserted when fifo_empty=1 or play=0.
REQ-027 pulse_count SHALL NOT clear on play.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, ear_out=IDLE_LEVEL, fifo_rd=0, busy=0, underrun=0, pulse_count=0, counter=0, low-byte latch=0.
REQ-029 Reset deassertion SHALL start no read until play=1 is sampled with fifo_empty=0.

Verification
REQ-030 Reset pulse mid-COUNT -> all outputs at reset values asynchronously; no fifo_rd afterwards while play=0.
REQ-031 FIFO {03,00}, play=1 -> two single-cycle fifo_rd strobes; ear_out 0->1; stays 1 for 3 ticks; then FETCH_LO with empty FIFO -> underrun=1, ear_out stays 1, pulse_count=1.
REQ-032 FIFO {02,00,00,00,01,00} -> ear_out 1 for 2 ticks, then 0 via marker, then 1 after the third word; pulse_count=2.
REQ-033 FIFO holds only {05}, then {00} arrives 20 cycles later -> underrun=1 in FETCH_HI, no fifo_rd while empty, then ear_out toggles and counts 5 ticks; underrun stays 1.
REQ-034 play dropped during COUNT -> next edge: busy=0, ear_out=0, underrun=0; no fifo_rd while FIFO is non-empty.
REQ-035 tick_en held high, FIFO {01,00} x4 -> ear_out toggles every 5 cycles; pulse_count=4.
